// File: rtl/parking_manager.sv
// Purpose : parking-lot occupancy tracker with per-hour peak log and end-of-day report readout.
// Latency : occupancy/hour/rejected update one cycle after the request; rd_max is combinational from rd_addr.
// Backpr.  : none; requests are sampled every cycle, refused enters pulse 'rejected', REPORT ignores requests.
//
// Ports   : clk, reset (async active-low, deassertion synchronized), enter/exit/increase_time requests,
//           occupancy/full/hour status, end_day, rush_start/rush_end with no_rush/no_end invalid flags,
//           rd_addr/rd_max report readout, rejected pulse, reject_count.
// Option  : define PARKING_REJECT_COUNT_EN to build the saturating refused-entry counter;
//           otherwise reject_count is tied to zero.
module parking_manager #(
    parameter int CAPACITY  = 3,
    parameter int HOURS     = 8,
    parameter int READ_HOLD = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enter,
    input  logic                          exit,
    input  logic                          increase_time,
    output logic [$clog2(CAPACITY+1)-1:0] occupancy,
    output logic                          full,
    output logic [$clog2(HOURS)-1:0]      hour,
    output logic                          end_day,
    output logic [$clog2(HOURS)-1:0]      rush_start,
    output logic [$clog2(HOURS)-1:0]      rush_end,
    output logic                          no_rush,
    output logic                          no_end,
    output logic [$clog2(HOURS)-1:0]      rd_addr,
    output logic [$clog2(CAPACITY+1)-1:0] rd_max,
    output logic                          rejected,
    output logic [7:0]                    reject_count
);
    localparam int OW = $clog2(CAPACITY+1);
    localparam int HW = $clog2(HOURS);

    typedef enum logic {DAY = 1'b0, REPORT = 1'b1} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_run;
    logic [OW-1:0]   r_occ;
    logic [HW-1:0]   r_hour;
    logic [OW-1:0]   r_log [HOURS];
    logic [HW-1:0]   r_rush_start;
    logic [HW-1:0]   r_rush_end;
    logic            r_no_rush;
    logic            r_no_end;
    logic            r_rejected;
    logic [HW-1:0]   r_rd_addr;
    logic [24:0]     r_hold;

    logic            w_act;
    logic            w_full;
    logic            w_last_hour;
    logic            w_reject;
    logic [OW-1:0]   w_occ_nxt;

    // r_run stays low for the first edge after reset release, so the reset
    // deassertion is seen synchronously and the second edge takes the first action.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_run <= 1'b0;
        else        r_run <= 1'b1;
    end

    assign w_act       = r_run && (r_state == DAY);
    assign w_full      = (r_occ == OW'(CAPACITY));
    assign w_last_hour = (r_hour == HW'(HOURS-1));

    // Simultaneous enter+exit cancel: no occupancy change and no refusal.
    always_comb begin
        w_occ_nxt = r_occ;
        w_reject  = 1'b0;
        if (enter && !exit) begin
            if (w_full) w_reject  = 1'b1;
            else        w_occ_nxt = r_occ + 1'b1;
        end else if (exit && !enter && (r_occ != '0)) begin
            w_occ_nxt = r_occ - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= DAY;
        else        r_state <= w_state_nxt;
    end

    // REPORT is terminal until reset.
    always_comb begin
        w_state_nxt = r_state;
        if (w_act && increase_time && w_last_hour) w_state_nxt = REPORT;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_occ        <= '0;
            r_hour       <= '0;
            r_rush_start <= '0;
            r_rush_end   <= '0;
            r_no_rush    <= 1'b1;
            r_no_end     <= 1'b1;
            r_rejected   <= 1'b0;
            for (int i = 0; i < HOURS; i++) r_log[i] <= '0;
        end else begin
            r_rejected <= w_act && w_reject;
            if (w_act) begin
                r_occ <= w_occ_nxt;
                if (w_occ_nxt > r_log[r_hour]) r_log[r_hour] <= w_occ_nxt;
                // Cars present at the hour change are the new hour's starting peak.
                if (increase_time && !w_last_hour) begin
                    r_hour                <= r_hour + 1'b1;
                    r_log[r_hour + 1'b1]  <= w_occ_nxt;
                end
                // next occupancy cannot be both CAPACITY and 0, so rush end is
                // only ever latched on a later cycle than rush start.
                if (r_no_rush && (w_occ_nxt == OW'(CAPACITY))) begin
                    r_rush_start <= r_hour;
                    r_no_rush    <= 1'b0;
                end else if (!r_no_rush && r_no_end && (w_occ_nxt == '0)) begin
                    r_rush_end <= r_hour;
                    r_no_end   <= 1'b0;
                end
            end
        end
    end

    // Report address walks the log, dwelling READ_HOLD cycles per entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_addr <= '0;
            r_hold    <= '0;
        end else if (r_run && (r_state == REPORT)) begin
            if (r_hold == 25'(READ_HOLD-1)) begin
                r_hold    <= '0;
                r_rd_addr <= (r_rd_addr == HW'(HOURS-1)) ? '0 : r_rd_addr + 1'b1;
            end else begin
                r_hold <= r_hold + 1'b1;
            end
        end
    end

`ifdef PARKING_REJECT_COUNT_EN
    logic [7:0] r_rej_cnt;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                        r_rej_cnt <= '0;
        else if (w_act && w_reject && (r_rej_cnt != 8'hFF)) r_rej_cnt <= r_rej_cnt + 1'b1;
    end
    assign reject_count = r_rej_cnt;
`else
    assign reject_count = 8'd0;
`endif

    assign occupancy  = r_occ;
    assign full       = w_full;
    assign hour       = r_hour;
    assign end_day    = (r_state == REPORT);
    assign rush_start = r_rush_start;
    assign rush_end   = r_rush_end;
    assign no_rush    = r_no_rush;
    assign no_end     = r_no_end;
    assign rd_addr    = r_rd_addr;
    assign rd_max     = r_log[r_rd_addr];
    assign rejected   = r_rejected;
endmodule

// File: tb/tb_parking_manager.sv
module tb_parking_manager;
    localparam int CAP = 3;
    localparam int HRS = 8;
    localparam int RH  = 1;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enter = 1'b0, exit = 1'b0, increase_time = 1'b0;
    logic [1:0] occupancy, rd_max;
    logic [2:0] hour, rush_start, rush_end, rd_addr;
    logic       full, end_day, no_rush, no_end, rejected;
    logic [7:0] reject_count;

    parking_manager #(.CAPACITY(CAP), .HOURS(HRS), .READ_HOLD(RH)) dut (
        .clk(clk), .reset(reset), .enter(enter), .exit(exit), .increase_time(increase_time),
        .occupancy(occupancy), .full(full), .hour(hour), .end_day(end_day),
        .rush_start(rush_start), .rush_end(rush_end), .no_rush(no_rush), .no_end(no_end),
        .rd_addr(rd_addr), .rd_max(rd_max), .rejected(rejected), .reject_count(reject_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    int m_occ, m_hour, m_rs, m_re, m_rd, m_hold, m_rejcnt;
    bit m_report, m_nr, m_ne, m_rej, m_skip;
    int m_peak [HRS];

    task automatic model_reset();
        m_occ = 0; m_hour = 0; m_rs = 0; m_re = 0; m_rd = 0; m_hold = 0; m_rejcnt = 0;
        m_report = 0; m_nr = 1; m_ne = 1; m_rej = 0;
        foreach (m_peak[i]) m_peak[i] = 0;
    endtask

    task automatic model_edge(input bit e, input bit x, input bit t);
        int nxt;
        if (m_skip) begin
            m_skip = 0;
            m_rej  = 0;
        end else if (!m_report) begin
            nxt   = m_occ;
            m_rej = 0;
            if (e && !x) begin
                if (m_occ == CAP) m_rej = 1;
                else nxt = m_occ + 1;
            end else if (x && !e && m_occ > 0) begin
                nxt = m_occ - 1;
            end
            if (nxt > m_peak[m_hour]) m_peak[m_hour] = nxt;
            if (m_nr && nxt == CAP) begin
                m_rs = m_hour; m_nr = 0;
            end else if (!m_nr && m_ne && nxt == 0) begin
                m_re = m_hour; m_ne = 0;
            end
`ifdef PARKING_REJECT_COUNT_EN
            if (m_rej && m_rejcnt < 255) m_rejcnt++;
`endif
            if (t) begin
                if (m_hour < HRS-1) begin
                    m_hour++;
                    m_peak[m_hour] = nxt;
                end else begin
                    m_report = 1; m_rd = 0; m_hold = 0;
                end
            end
            m_occ = nxt;
        end else begin
            m_rej = 0;
            m_hold++;
            if (m_hold == RH) begin
                m_hold = 0;
                m_rd = (m_rd + 1) % HRS;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".occupancy"},    occupancy,    m_occ);
        chk({tag, ".full"},         full,         (m_occ == CAP) ? 1 : 0);
        chk({tag, ".hour"},         hour,         m_hour);
        chk({tag, ".end_day"},      end_day,      m_report);
        chk({tag, ".rush_start"},   rush_start,   m_rs);
        chk({tag, ".rush_end"},     rush_end,     m_re);
        chk({tag, ".no_rush"},      no_rush,      m_nr);
        chk({tag, ".no_end"},       no_end,       m_ne);
        chk({tag, ".rd_addr"},      rd_addr,      m_rd);
        chk({tag, ".rd_max"},       rd_max,       m_peak[m_rd]);
        chk({tag, ".rejected"},     rejected,     m_rej);
        chk({tag, ".reject_count"}, reject_count, m_rejcnt);
    endtask

    // Called at posedge+1; drives inputs, waits one edge, checks at posedge+1.
    task automatic step(input bit e, input bit x, input bit t, input string tag);
        enter = e; exit = x; increase_time = t;
        @(posedge clk);
        model_edge(e, x, t);
        #1;
        check_all(tag);
    endtask

    // Asserts reset between edges, checks the asynchronous effect before the next
    // edge, then releases it with an enter held on the first (ignored) edge.
    task automatic do_reset(input string tag);
        reset = 1'b0;
        enter = 1'b0; exit = 1'b0; increase_time = 1'b0;
        #2;
        model_reset();
        chk({tag, ".rst_occ"},   occupancy, 0);
        chk({tag, ".rst_endday"}, end_day,  0);
        chk({tag, ".rst_norush"}, no_rush,  1);
        check_all({tag, ".rst"});
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        m_skip = 1;
        step(1'b1, 1'b0, 1'b0, {tag, ".sync"});
        enter = 1'b0;
    endtask

    typedef struct {
        bit e, x, t;
        int occ, fl, rej, hr;
    } vec_t;
    vec_t vecs [12];

    int exp_pk [HRS];
    int exp_rc;

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        model_reset();
        m_skip = 0;
        #7;

        // ---- fill/reject/cancel/empty table ----
        vecs[0]  = '{1,0,0, 1,0,0,0};
        vecs[1]  = '{1,0,0, 2,0,0,0};
        vecs[2]  = '{1,0,0, 3,1,0,0};
        vecs[3]  = '{1,0,0, 3,1,1,0};
        vecs[4]  = '{1,1,0, 3,1,0,0};
        vecs[5]  = '{0,1,0, 2,0,0,0};
        vecs[6]  = '{0,1,0, 1,0,0,0};
        vecs[7]  = '{0,1,0, 0,0,0,0};
        vecs[8]  = '{0,1,0, 0,0,0,0};
        vecs[9]  = '{1,1,0, 0,0,0,0};
        vecs[10] = '{0,0,1, 0,0,0,1};
        vecs[11] = '{1,0,1, 1,0,0,2};
        do_reset("t1");
        for (int i = 0; i < 12; i++) begin
            step(vecs[i].e, vecs[i].x, vecs[i].t, $sformatf("t1v%0d", i));
            chk($sformatf("t1v%0d.tbl_occ", i),  occupancy, vecs[i].occ);
            chk($sformatf("t1v%0d.tbl_full", i), full,      vecs[i].fl);
            chk($sformatf("t1v%0d.tbl_rej", i),  rejected,  vecs[i].rej);
            chk($sformatf("t1v%0d.tbl_hour", i), hour,      vecs[i].hr);
        end
        chk("t1.rush_start", rush_start, 0);
        chk("t1.no_rush",    no_rush,    0);

        // ---- rush hours 2..4, day end, report readout ----
        do_reset("t2");
        step(0,0,1,"t2"); step(0,0,1,"t2");
        step(1,0,0,"t2"); step(1,0,0,"t2"); step(1,0,0,"t2");
        step(0,0,1,"t2"); step(0,0,1,"t2");
        step(0,1,0,"t2"); step(0,1,0,"t2"); step(0,1,0,"t2");
        for (int i = 0; i < 8; i++) step(0,0,1,"t2t");
        chk("t2.end_day",    end_day,    1);
        chk("t2.rush_start", rush_start, 2);
        chk("t2.rush_end",   rush_end,   4);
        exp_pk = '{0,0,3,3,3,0,0,0};
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("t2.rd_max[%0d]", rd_addr), rd_max, exp_pk[rd_addr]);
            step(1,0,0,"t2r");
        end
        chk("t2.occ_frozen", occupancy, 0);

        // ---- quiet day: no rush, address walk and wrap ----
        do_reset("t3");
        step(1,0,0,"t3"); step(1,0,0,"t3");
        for (int i = 0; i < 8; i++) step(0,0,1,"t3t");
        chk("t3.no_rush", no_rush, 1);
        chk("t3.no_end",  no_end,  1);
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("t3.rd_addr%0d", i), rd_addr, i % 8);
            step(0,0,0,"t3r");
        end

        // ---- reset asserted mid-report ----
        do_reset("t4");
        chk("t4.hour0",    hour,     0);
        chk("t4.rd_addr0", rd_addr,  0);
        chk("t4.rejected0", rejected, 0);

        // ---- refused-entry counter ----
        do_reset("t5");
        for (int i = 0; i < 3; i++) step(1,0,0,"t5f");
        for (int i = 0; i < 5; i++) step(1,0,0,"t5r");
`ifdef PARKING_REJECT_COUNT_EN
        exp_rc = 5;
`else
        exp_rc = 0;
`endif
        chk("t5.reject_count", reject_count, exp_rc);

        // ---- randomized days against the model ----
        for (int d = 0; d < 6; d++) begin
            do_reset($sformatf("rnd%0d", d));
            for (int c = 0; c < 250; c++) begin
                step(($urandom_range(99) < 45), ($urandom_range(99) < 35),
                     ($urandom_range(99) < 6), $sformatf("rnd%0d.c%0d", d, c));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
